// File: rtl/systolic_seq_ctrl_pkg.sv
// rtl/systolic_seq_ctrl_pkg.sv - state encoding and derived sizes shared by the systolic sequencer
package systolic_seq_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_FEED  = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   localparam int N_DEF     = 3;
   localparam int DW_DEF    = 8;
   localparam int CW_DEF    = 17;
   localparam int SKEW_DEF  = 1;
   localparam int DRAIN_DEF = 2 * N_DEF;

   // skewed lanes need N-1 extra cycles before the last lane has emptied
   function automatic int calc_feed_len(input int n, input int skew);
      return (skew != 0) ? 2 * n - 1 : n;
   endfunction

   // phase counter must hold the longest phase index of FEED or DRAIN
   function automatic int calc_cnt_w(input int n, input int skew, input int drain);
      int m;
      m = calc_feed_len(n, skew);
      if (drain > m) m = drain;
      return $clog2(m + 1);
   endfunction

   localparam int FEED_LEN = calc_feed_len(N_DEF, SKEW_DEF);
   localparam int CNT_W    = calc_cnt_w(N_DEF, SKEW_DEF, DRAIN_DEF);

endpackage

// File: rtl/systolic_seq_ctrl_if.sv
// rtl/systolic_seq_ctrl_if.sv - host-side load/start/result bus of the systolic sequencer
interface systolic_seq_ctrl_if
   import systolic_seq_ctrl_pkg::*;
#(
   parameter int N  = N_DEF,
   parameter int DW = DW_DEF,
   parameter int CW = CW_DEF
);
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   logic              ld_valid;
   logic              ld_sel;
   logic [IW-1:0]     ld_row;
   logic [IW-1:0]     ld_col;
   logic [DW-1:0]     ld_data;
   logic              ld_ready;
   logic              start;
   logic              busy;
   logic              done;
   logic              res_valid;
   logic [N*N*CW-1:0] res_data;

   modport master (
      output ld_valid, ld_sel, ld_row, ld_col, ld_data, start,
      input  ld_ready, busy, done, res_valid, res_data
   );

   modport slave (
      input  ld_valid, ld_sel, ld_row, ld_col, ld_data, start,
      output ld_ready, busy, done, res_valid, res_data
   );

endinterface

// File: rtl/systolic_seq_ctrl_lane_mux.sv
// rtl/systolic_seq_ctrl_lane_mux.sv - element one operand lane drives in a given feed cycle
module systolic_lane_mux
   import systolic_seq_ctrl_pkg::*;
#(
   parameter int N    = N_DEF,
   parameter int DW   = DW_DEF,
   parameter int SKEW = SKEW_DEF,
   parameter int LANE = 0,
   parameter int TW   = CNT_W
) (
   input  logic [TW-1:0]   t,
   input  logic [N*DW-1:0] vec,
   output logic [DW-1:0]   elem
);

   // lane LANE starts LANE*SKEW cycles late and feeds zero outside its N-cycle window
   always_comb begin
      elem = '0;
      for (int k = 0; k < N; k++) begin
         if (int'(t) == k + LANE * SKEW) elem = vec[k*DW +: DW];
      end
   end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// rtl/systolic_seq_ctrl.sv - operand store, feed sequencer and result capture for the systolic array
module systolic_seq_ctrl
   import systolic_seq_ctrl_pkg::*;
#(
   parameter int N         = N_DEF,
   parameter int DW        = DW_DEF,
   parameter int CW        = CW_DEF,
   parameter int SKEW      = SKEW_DEF,
   parameter int DRAIN_CYC = DRAIN_DEF
) (
   input  logic              clk,
   input  logic              reset,
   systolic_seq_ctrl_if.slave io,
   output logic              arr_clr,
   output logic [N*DW-1:0]   arr_a,
   output logic [N*DW-1:0]   arr_b,
   input  logic [N*N*CW-1:0] arr_c
);

   localparam int FEED_CYC = calc_feed_len(N, SKEW);
   localparam int PW       = calc_cnt_w(N, SKEW, DRAIN_CYC);
   localparam logic [PW-1:0] FEED_LAST  = PW'(FEED_CYC - 1);
   localparam logic [PW-1:0] DRAIN_LAST = PW'(DRAIN_CYC - 1);

   state_t          state, nxt_state;
   logic [PW-1:0]   cnt, nxt_cnt;
   logic            capture;
   logic            ld_ok;
   logic [N*DW-1:0] a_row [N];
   logic [N*DW-1:0] b_col [N];
   logic [N*DW-1:0] mux_a, mux_b;

   assign ld_ok = io.ld_valid && io.ld_ready && (int'(io.ld_row) < N) && (int'(io.ld_col) < N);

   // lane muxes look at the next phase index so the lane outputs can be registered
   for (genvar g = 0; g < N; g++) begin : g_lane
      systolic_lane_mux #(.N(N), .DW(DW), .SKEW(SKEW), .LANE(g), .TW(PW)) u_mux_a (
         .t(nxt_cnt), .vec(a_row[g]), .elem(mux_a[g*DW +: DW])
      );
      systolic_lane_mux #(.N(N), .DW(DW), .SKEW(SKEW), .LANE(g), .TW(PW)) u_mux_b (
         .t(nxt_cnt), .vec(b_col[g]), .elem(mux_b[g*DW +: DW])
      );
   end

   // next state and phase index; counter restarts from zero on every state entry
   always_comb begin
      nxt_state = state;
      nxt_cnt   = cnt;
      capture   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (io.start) begin
               nxt_state = ST_CLEAR;
               nxt_cnt   = '0;
            end
         end
         ST_CLEAR: begin
            nxt_state = ST_FEED;
            nxt_cnt   = '0;
         end
         ST_FEED: begin
            if (cnt == FEED_LAST) begin
               nxt_state = ST_DRAIN;
               nxt_cnt   = '0;
            end else begin
               nxt_cnt = cnt + PW'(1);
            end
         end
         ST_DRAIN: begin
            if (cnt == DRAIN_LAST) begin
               nxt_state = ST_IDLE;
               nxt_cnt   = '0;
               capture   = 1'b1;
            end else begin
               nxt_cnt = cnt + PW'(1);
            end
         end
         default: begin
            nxt_state = ST_IDLE;
            nxt_cnt   = '0;
         end
      endcase
   end

   // state register and all registered outputs, decoded from the upcoming state
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_IDLE;
         cnt          <= '0;
         arr_clr      <= 1'b0;
         arr_a        <= '0;
         arr_b        <= '0;
         io.busy      <= 1'b0;
         io.ld_ready  <= 1'b1;
         io.done      <= 1'b0;
         io.res_valid <= 1'b0;
         io.res_data  <= '0;
      end else begin
         state       <= nxt_state;
         cnt         <= nxt_cnt;
         arr_clr     <= (nxt_state == ST_CLEAR);
         arr_a       <= (nxt_state == ST_FEED) ? mux_a : '0;
         arr_b       <= (nxt_state == ST_FEED) ? mux_b : '0;
         io.busy     <= (nxt_state != ST_IDLE);
         io.ld_ready <= (nxt_state == ST_IDLE);
         io.done     <= capture;
         if (capture) begin
            io.res_data  <= arr_c;
            io.res_valid <= 1'b1;
         end else if (state == ST_IDLE && io.start) begin
            io.res_valid <= 1'b0;
         end
      end
   end

   // operand store: A kept by row and B by column so each lane mux reads one vector
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N; i++) begin
            a_row[i] <= '0;
            b_col[i] <= '0;
         end
      end else if (ld_ok) begin
         if (io.ld_sel) b_col[io.ld_col][io.ld_row*DW +: DW] <= io.ld_data;
         else           a_row[io.ld_row][io.ld_col*DW +: DW] <= io.ld_data;
      end
   end

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// tb/tb_systolic_seq_ctrl.sv - randomized self-checking bench for systolic_seq_ctrl
module tb_systolic_seq_ctrl;

   localparam int N       = 3;
   localparam int DW      = 8;
   localparam int CW      = 17;
   localparam int IW      = 2;
   localparam int DRAIN   = 2 * N;
   localparam int FL1     = 2 * N - 1;
   localparam int FL0     = N;
   localparam int DONE1   = 2 + FL1 + DRAIN;
   localparam int DONE0   = 2 + FL0 + DRAIN;
   localparam int RUN_CYC = 20;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   systolic_seq_ctrl_if #(.N(N), .DW(DW), .CW(CW)) bus1 ();
   systolic_seq_ctrl_if #(.N(N), .DW(DW), .CW(CW)) bus0 ();

   logic              arr_clr1, arr_clr0;
   logic [N*DW-1:0]   arr_a1, arr_b1, arr_a0, arr_b0;
   logic [N*N*CW-1:0] arr_c1, arr_c0;
   assign arr_c0 = '0;

   systolic_seq_ctrl #(.N(N), .DW(DW), .CW(CW), .SKEW(1), .DRAIN_CYC(DRAIN)) dut1 (
      .clk(clk), .reset(rst), .io(bus1), .arr_clr(arr_clr1),
      .arr_a(arr_a1), .arr_b(arr_b1), .arr_c(arr_c1)
   );

   systolic_seq_ctrl #(.N(N), .DW(DW), .CW(CW), .SKEW(0), .DRAIN_CYC(DRAIN)) dut0 (
      .clk(clk), .reset(rst), .io(bus0), .arr_clr(arr_clr0),
      .arr_a(arr_a0), .arr_b(arr_b0), .arr_c(arr_c0)
   );

   // output-stationary array attached to dut1: a moves right, b moves down, each PE accumulates
   logic [DW-1:0] pa [N][N];
   logic [DW-1:0] pb [N][N];
   logic [CW-1:0] acc [N][N];

   always @(posedge clk) begin
      if (rst || arr_clr1) begin
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
               pa[i][j]  <= '0;
               pb[i][j]  <= '0;
               acc[i][j] <= '0;
            end
      end else begin
         for (int i = 0; i < N; i++) begin
            pa[i][0] <= arr_a1[i*DW +: DW];
            pb[0][i] <= arr_b1[i*DW +: DW];
            for (int j = 1; j < N; j++) begin
               pa[i][j] <= pa[i][j-1];
               pb[j][i] <= pb[j-1][i];
            end
         end
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
               acc[i][j] <= acc[i][j] + (CW'(pa[i][j]) * CW'(pb[i][j]));
      end
   end

   always_comb begin
      arr_c1 = '0;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            arr_c1[(i*N+j)*CW +: CW] = acc[i][j];
   end

   int n_cmp = 0;
   int n_err = 0;
   int ma [N][N];
   int mb [N][N];

   logic [N*DW-1:0] la1 [0:RUN_CYC];
   logic [N*DW-1:0] lb1 [0:RUN_CYC];
   logic [N*DW-1:0] la0 [0:RUN_CYC];
   logic [N*DW-1:0] lb0 [0:RUN_CYC];
   logic            lclr1 [0:RUN_CYC];
   logic            lrdy1 [0:RUN_CYC];
   int done1_cyc, done0_cyc, done1_cnt;

   function automatic logic [N*DW-1:0] exp_lane(input bit is_b, input int t, input int skew);
      logic [N*DW-1:0] v;
      v = '0;
      for (int l = 0; l < N; l++) begin
         int k;
         k = t - l * skew;
         if (k >= 0 && k < N) v[l*DW +: DW] = is_b ? DW'(mb[k][l]) : DW'(ma[l][k]);
      end
      return v;
   endfunction

   function automatic logic [N*N*CW-1:0] exp_res();
      logic [N*N*CW-1:0] r;
      r = '0;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            int s;
            s = 0;
            for (int k = 0; k < N; k++) s += ma[i][k] * mb[k][j];
            r[(i*N+j)*CW +: CW] = CW'(s);
         end
      return r;
   endfunction

   task automatic set_ld(input logic v, input logic sel, input int r, input int c, input int d);
      bus1.ld_valid = v;  bus0.ld_valid = v;
      bus1.ld_sel = sel;  bus0.ld_sel = sel;
      bus1.ld_row = IW'(r); bus0.ld_row = IW'(r);
      bus1.ld_col = IW'(c); bus0.ld_col = IW'(c);
      bus1.ld_data = DW'(d); bus0.ld_data = DW'(d);
   endtask

   task automatic set_start(input logic s);
      bus1.start = s;
      bus0.start = s;
   endtask

   task automatic write_elem(input logic sel, input int r, input int c, input int d);
      set_ld(1'b1, sel, r, c, d);
      @(negedge clk);
      set_ld(1'b0, 1'b0, 0, 0, 0);
      if (r < N && c < N) begin
         if (sel) mb[r][c] = d;
         else     ma[r][c] = d;
      end
   endtask

   task automatic load_fixed();
      int fb [9] = '{2, 1, 3, 4, 5, 7, 6, 9, 8};
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            write_elem(1'b0, i, j, i * N + j + 1);
            write_elem(1'b1, i, j, fb[i*N+j]);
         end
   endtask

   // start in cycle 0, log outputs per cycle; optional A write (and start) injected in cycle inj_cyc
   task automatic run(input int inj_cyc, input logic inj_start, input int inj_r, input int inj_c, input int inj_d);
      done1_cyc = -1; done0_cyc = -1; done1_cnt = 0;
      for (int c = 0; c <= RUN_CYC; c++) begin
         la1[c] = arr_a1; lb1[c] = arr_b1; lclr1[c] = arr_clr1; lrdy1[c] = bus1.ld_ready;
         la0[c] = arr_a0; lb0[c] = arr_b0;
         if (bus1.done) begin
            done1_cnt++;
            if (done1_cyc < 0) done1_cyc = c;
         end
         if (bus0.done && done0_cyc < 0) done0_cyc = c;
         set_start((c == 0) || (c == inj_cyc && inj_start));
         if (c == inj_cyc) set_ld(1'b1, 1'b0, inj_r, inj_c, inj_d);
         else              set_ld(1'b0, 1'b0, 0, 0, 0);
         @(negedge clk);
      end
      set_start(1'b0);
      set_ld(1'b0, 1'b0, 0, 0, 0);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_start(1'b0);
      set_ld(1'b0, 1'b0, 0, 0, 0);
      repeat (2) @(negedge clk);
      n_cmp++; if ({arr_clr1, bus1.done, bus1.busy, bus1.res_valid} !== 4'b0) begin n_err++;
         $display("FAIL reset_flags got=%b exp=0000", {arr_clr1, bus1.done, bus1.busy, bus1.res_valid}); end
      n_cmp++; if ({arr_a1, arr_b1} !== '0) begin n_err++;
         $display("FAIL reset_lanes got=%h exp=0", {arr_a1, arr_b1}); end
      n_cmp++; if (bus1.res_data !== '0) begin n_err++;
         $display("FAIL reset_res got=%h exp=0", bus1.res_data); end
      n_cmp++; if (bus1.ld_ready !== 1'b1) begin n_err++;
         $display("FAIL reset_ld_ready got=%b exp=1", bus1.ld_ready); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_skew();
      logic [N*DW-1:0] tbl [5] = '{24'h000001, 24'h000402, 24'h070503, 24'h080600, 24'h090000};
      load_fixed();
      run(-1, 1'b0, 0, 0, 0);
      for (int t = 0; t < 5; t++) begin
         n_cmp++; if (la1[t+2] !== tbl[t]) begin n_err++;
            $display("FAIL skew_table t=%0d got=%h exp=%h", t, la1[t+2], tbl[t]); end
      end
      for (int c = 0; c <= RUN_CYC; c++) begin
         int t;
         logic [N*DW-1:0] ea, eb;
         t = c - 2;
         ea = (t >= 0 && t < FL1) ? exp_lane(1'b0, t, 1) : '0;
         eb = (t >= 0 && t < FL1) ? exp_lane(1'b1, t, 1) : '0;
         n_cmp++; if (la1[c] !== ea) begin n_err++; $display("FAIL skew_a cyc=%0d got=%h exp=%h", c, la1[c], ea); end
         n_cmp++; if (lb1[c] !== eb) begin n_err++; $display("FAIL skew_b cyc=%0d got=%h exp=%h", c, lb1[c], eb); end
         n_cmp++; if (lclr1[c] !== (c == 1)) begin n_err++; $display("FAIL skew_clr cyc=%0d got=%b exp=%b", c, lclr1[c], c == 1); end
      end
   endtask

   task automatic test_noskew();
      run(-1, 1'b0, 0, 0, 0);
      for (int c = 0; c <= RUN_CYC; c++) begin
         int t;
         logic [N*DW-1:0] ea, eb;
         t = c - 2;
         ea = (t >= 0 && t < FL0) ? exp_lane(1'b0, t, 0) : '0;
         eb = (t >= 0 && t < FL0) ? exp_lane(1'b1, t, 0) : '0;
         n_cmp++; if (la0[c] !== ea) begin n_err++; $display("FAIL noskew_a cyc=%0d got=%h exp=%h", c, la0[c], ea); end
         n_cmp++; if (lb0[c] !== eb) begin n_err++; $display("FAIL noskew_b cyc=%0d got=%h exp=%h", c, lb0[c], eb); end
      end
      n_cmp++; if (done0_cyc !== DONE0) begin n_err++;
         $display("FAIL noskew_done_cyc got=%0d exp=%0d", done0_cyc, DONE0); end
   endtask

   task automatic test_product();
      int cexp [9] = '{28, 38, 41, 64, 83, 95, 100, 128, 149};
      run(-1, 1'b0, 0, 0, 0);
      n_cmp++; if (done1_cyc !== DONE1) begin n_err++; $display("FAIL prod_done_cyc got=%0d exp=%0d", done1_cyc, DONE1); end
      n_cmp++; if (bus1.res_valid !== 1'b1) begin n_err++; $display("FAIL prod_res_valid got=%b exp=1", bus1.res_valid); end
      for (int e = 0; e < N * N; e++) begin
         n_cmp++; if (bus1.res_data[e*CW +: CW] !== CW'(cexp[e])) begin n_err++;
            $display("FAIL prod_c%0d got=%0d exp=%0d", e, bus1.res_data[e*CW +: CW], cexp[e]); end
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 4; it++) begin
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
               write_elem(1'b0, i, j, int'($urandom_range(0, 255)));
               write_elem(1'b1, i, j, int'($urandom_range(0, 255)));
            end
         run(-1, 1'b0, 0, 0, 0);
         n_cmp++; if (done1_cyc !== DONE1) begin n_err++; $display("FAIL rand_done_cyc it=%0d got=%0d exp=%0d", it, done1_cyc, DONE1); end
         n_cmp++; if (bus1.res_data !== exp_res()) begin n_err++;
            $display("FAIL rand_res it=%0d got=%h exp=%h", it, bus1.res_data, exp_res()); end
         for (int c = 2; c < 2 + FL1; c++) begin
            n_cmp++; if (la1[c] !== exp_lane(1'b0, c - 2, 1) || lb1[c] !== exp_lane(1'b1, c - 2, 1)) begin n_err++;
               $display("FAIL rand_lanes it=%0d cyc=%0d got=%h/%h exp=%h/%h", it, c, la1[c], lb1[c],
                        exp_lane(1'b0, c - 2, 1), exp_lane(1'b1, c - 2, 1)); end
         end
         for (int c = 2; c < 2 + FL0; c++) begin
            n_cmp++; if (la0[c] !== exp_lane(1'b0, c - 2, 0) || lb0[c] !== exp_lane(1'b1, c - 2, 0)) begin n_err++;
               $display("FAIL rand_lanes0 it=%0d cyc=%0d got=%h/%h", it, c, la0[c], lb0[c]); end
         end
      end
   endtask

   task automatic test_busy();
      load_fixed();
      run(3, 1'b1, 0, 0, 255);
      n_cmp++; if (lrdy1[3] !== 1'b0) begin n_err++; $display("FAIL busy_ld_ready got=%b exp=0", lrdy1[3]); end
      n_cmp++; if (done1_cnt !== 1 || done1_cyc !== DONE1) begin n_err++;
         $display("FAIL busy_restart dones=%0d cyc=%0d exp=1/%0d", done1_cnt, done1_cyc, DONE1); end
      n_cmp++; if (bus1.res_data !== exp_res()) begin n_err++;
         $display("FAIL busy_res got=%h exp=%h", bus1.res_data, exp_res()); end
      run(-1, 1'b0, 0, 0, 0);
      n_cmp++; if (bus1.res_data !== exp_res()) begin n_err++;
         $display("FAIL busy_rerun_res got=%h exp=%h", bus1.res_data, exp_res()); end
   endtask

   task automatic test_boundary();
      write_elem(1'b0, 3, 0, 8'h55);
      write_elem(1'b1, 0, 3, 8'h55);
      ma[2][2] = 1;
      run(0, 1'b0, 2, 2, 1);
      n_cmp++; if (bus1.res_data[8*CW +: CW] !== CW'(85)) begin n_err++;
         $display("FAIL bound_c22 got=%0d exp=85", bus1.res_data[8*CW +: CW]); end
      n_cmp++; if (bus1.res_data !== exp_res()) begin n_err++;
         $display("FAIL bound_res got=%h exp=%h", bus1.res_data, exp_res()); end
   endtask

   task automatic test_reset_mid();
      set_start(1'b1);
      @(negedge clk);
      set_start(1'b0);
      repeat (8) @(negedge clk);
      n_cmp++; if (bus1.busy !== 1'b1) begin n_err++; $display("FAIL rstmid_busy_before got=%b exp=1", bus1.busy); end
      rst = 1'b1;
      @(negedge clk);
      n_cmp++; if ({arr_clr1, bus1.done, bus1.busy, bus1.res_valid, bus1.ld_ready} !== 5'b00001) begin n_err++;
         $display("FAIL rstmid_flags got=%b exp=00001", {arr_clr1, bus1.done, bus1.busy, bus1.res_valid, bus1.ld_ready}); end
      n_cmp++; if ({arr_a1, arr_b1} !== '0 || bus1.res_data !== '0) begin n_err++;
         $display("FAIL rstmid_data got=%h/%h exp=0", {arr_a1, arr_b1}, bus1.res_data); end
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            ma[i][j] = 0;
            mb[i][j] = 0;
         end
      run(-1, 1'b0, 0, 0, 0);
      n_cmp++; if (done1_cyc !== DONE1) begin n_err++; $display("FAIL rstmid_done_cyc got=%0d exp=%0d", done1_cyc, DONE1); end
      n_cmp++; if (bus1.res_data[0 +: CW] !== '0 || bus1.res_data !== exp_res()) begin n_err++;
         $display("FAIL rstmid_res got=%h exp=%h", bus1.res_data, exp_res()); end
   endtask

   task automatic test_back_to_back();
      int c;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            write_elem(1'b0, i, j, int'($urandom_range(0, 255)));
            write_elem(1'b1, i, j, int'($urandom_range(0, 255)));
         end
      set_start(1'b1);
      c = 0;
      @(negedge clk);
      set_start(1'b0);
      c = 1;
      while (bus1.done !== 1'b1 && c < 30) begin
         @(negedge clk);
         c++;
      end
      n_cmp++; if (c !== DONE1) begin n_err++; $display("FAIL b2b_first_done got=%0d exp=%0d", c, DONE1); end
      n_cmp++; if (bus1.res_data !== exp_res()) begin n_err++;
         $display("FAIL b2b_first_res got=%h exp=%h", bus1.res_data, exp_res()); end
      set_start(1'b1);
      @(negedge clk);
      set_start(1'b0);
      n_cmp++; if ({arr_clr1, bus1.busy, bus1.res_valid} !== 3'b110) begin n_err++;
         $display("FAIL b2b_restart got=%b exp=110", {arr_clr1, bus1.busy, bus1.res_valid}); end
      c = 1;
      while (bus1.done !== 1'b1 && c < 30) begin
         @(negedge clk);
         c++;
      end
      n_cmp++; if (c !== DONE1) begin n_err++; $display("FAIL b2b_second_done got=%0d exp=%0d", c, DONE1); end
      n_cmp++; if (bus1.res_data !== exp_res() || bus1.res_valid !== 1'b1) begin n_err++;
         $display("FAIL b2b_second_res got=%h exp=%h", bus1.res_data, exp_res()); end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin
      set_start(1'b0);
      set_ld(1'b0, 1'b0, 0, 0, 0);
      test_reset();
      test_skew();
      test_noskew();
      test_product();
      test_random();
      test_busy();
      test_boundary();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
